// File: rtl/tb_mem_arb_pkg.sv
// Shared types and constants for the testbench RAM port arbiter.
//   master_idx_t  : index of one of the two masters (0 = core data, 1 = aux agent)
//   rsp_entry_t   : one response-pipeline slot {valid, owner}
//   other_master  : returns the opposite master index (round-robin pointer update)
package tb_mem_arb_pkg;

  localparam int NUM_MASTERS     = 2;
  localparam int MAX_RAM_LATENCY = 4;

  typedef logic master_idx_t;

  typedef struct packed {
    logic        valid;
    master_idx_t owner;
  } rsp_entry_t;

  function automatic master_idx_t other_master(input master_idx_t m);
    return ~m;
  endfunction

endpackage

// File: rtl/tb_mem_port_arbiter_if.sv
// Bus bundle between two OBI-style masters, the arbiter and the RAM data port.
//
// Handshake: a master raises m*_req_i together with a stable address/we/be/wdata
// and keeps all of them stable until the cycle in which m*_gnt_o is high; that
// cycle is the transfer. Every transfer (read or write) returns exactly one
// single-cycle m*_rvalid_o pulse, in grant order, with no back-pressure. The RAM
// side accepts s_req_o unconditionally and returns s_rdata_i a fixed number of
// cycles later.
//
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the RAM port)
//   master : the environment's view (drives master requests and RAM read data)
interface tb_mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  m0_req_i;
  logic                  m0_gnt_o;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [3:0]            m0_be_i;
  logic [31:0]           m0_wdata_i;
  logic                  m0_rvalid_o;
  logic [31:0]           m0_rdata_o;

  logic                  m1_req_i;
  logic                  m1_gnt_o;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [3:0]            m1_be_i;
  logic [31:0]           m1_wdata_i;
  logic                  m1_rvalid_o;
  logic [31:0]           m1_rdata_o;

  logic                  s_req_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic                  s_we_o;
  logic [3:0]            s_be_o;
  logic [31:0]           s_wdata_o;
  logic [31:0]           s_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_rdata_i
  );

endinterface

// File: rtl/tb_mem_rsp_pipe.sv
// Fixed-latency response tracker: a RAM_LATENCY-deep shift register of
// {valid, owner} entries. One entry is pushed every cycle (valid=0 when nothing
// was granted); the tail entry lines up with the RAM read data.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the pipe)
//   push_i        : entry for the grant made this cycle
//   tail_o        : entry whose response is on s_rdata_i this cycle
module tb_mem_rsp_pipe
  import tb_mem_arb_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rsp_entry_t push_i,
  output rsp_entry_t tail_o
);

  // Legal latency is 1..MAX_RAM_LATENCY; anything outside is clamped.
  localparam int DEPTH = (RAM_LATENCY < 1) ? 1 :
                         (RAM_LATENCY > MAX_RAM_LATENCY) ? MAX_RAM_LATENCY : RAM_LATENCY;

  rsp_entry_t stage [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail_o = stage[DEPTH-1];

endmodule

// File: rtl/tb_mem_port_arbiter.sv
// Shares the single data port of the testbench RAM between the core data
// interface (master 0) and an auxiliary testbench agent (master 1).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : both master ports and the RAM port (see the interface)
//   starve_o      : per-master sticky flag, set after MAX_WAIT ungranted cycles
//   grant_cnt_o   : per-master saturating count of accepted requests
// Arbitration is combinational; ADDR_WIDTH must match the interface instance.
module tb_mem_port_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  parameter int MAX_WAIT    = 64,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tb_mem_port_arbiter_if.slave   bus,
  output logic [1:0]             starve_o,
  output logic [1:0][15:0]       grant_cnt_o
);

  localparam int              WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

  logic [NUM_MASTERS-1:0]          req;
  logic [NUM_MASTERS-1:0]          gnt;
  master_idx_t                     pref;
  logic [NUM_MASTERS-1:0][WW-1:0]  wait_cnt;

  logic [ADDR_WIDTH-1:0] s_addr;
  logic                  s_we;
  logic [3:0]            s_be;
  logic [31:0]           s_wdata;

  rsp_entry_t push, tail;
  logic       m0_hit, m1_hit;

  assign req = {bus.m1_req_i, bus.m0_req_i};

  // Grants are forced low while reset is asserted so no request is accepted
  // into a pipeline that is being cleared.
  always_comb begin
    gnt = '0;
    if (rst_ni) begin
      if (&req) begin
        if (FIXED_PRIO != 0 || pref == 1'b0) gnt = 2'b01;
        else                                 gnt = 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  assign bus.m0_gnt_o = gnt[0];
  assign bus.m1_gnt_o = gnt[1];

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_wdata = '0;
    if (gnt[0]) begin
      s_addr  = bus.m0_addr_i;
      s_we    = bus.m0_we_i;
      s_be    = bus.m0_be_i;
      s_wdata = bus.m0_wdata_i;
    end else if (gnt[1]) begin
      s_addr  = bus.m1_addr_i;
      s_we    = bus.m1_we_i;
      s_be    = bus.m1_be_i;
      s_wdata = bus.m1_wdata_i;
    end
  end

  assign bus.s_req_o   = |gnt;
  assign bus.s_addr_o  = s_addr;
  assign bus.s_we_o    = s_we;
  assign bus.s_be_o    = s_be;
  assign bus.s_wdata_o = s_wdata;

  assign push = {|gnt, gnt[1]};

  tb_mem_rsp_pipe #(
    .RAM_LATENCY (RAM_LATENCY)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .tail_o (tail)
  );

  assign m0_hit = tail.valid && (tail.owner == 1'b0);
  assign m1_hit = tail.valid && (tail.owner == 1'b1);

  assign bus.m0_rvalid_o = m0_hit;
  assign bus.m1_rvalid_o = m1_hit;
  assign bus.m0_rdata_o  = m0_hit ? bus.s_rdata_i : 32'h0;
  assign bus.m1_rdata_o  = m1_hit ? bus.s_rdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pref        <= 1'b0;
      wait_cnt    <= '0;
      starve_o    <= '0;
      grant_cnt_o <= '0;
    end else begin
      // The master that was just served loses preference next time.
      if (|gnt) pref <= other_master(gnt[1]);
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (gnt[m] && grant_cnt_o[m] != 16'hFFFF) grant_cnt_o[m] <= grant_cnt_o[m] + 16'd1;
        if (req[m] && !gnt[m]) begin
          if (wait_cnt[m] != WAIT_MAX) wait_cnt[m] <= wait_cnt[m] + WW'(1);
          // Flag on the edge where the count reaches MAX_WAIT.
          if (wait_cnt[m] == WAIT_MAX - WW'(1)) starve_o[m] <= 1'b1;
        end else begin
          wait_cnt[m] <= '0;
        end
      end
    end
  end

endmodule
